alu_issue_ctrl: RTL and testbench

- Initiator side of the execute-stage ALU interface. Accepts one decoded instruction per request over a valid/ready handshake.
- Maps opcode/funct to the 4-bit ALU control code and selects the ALU operands (register or extended immediate). Drives the combinational ALU, then registers its result and zero flag.
- Returns result, branch decision and branch target to the pipeline control over a second valid/ready handshake.

---
 rtl/alu_pkg.sv | 56 +++++
 rtl/alu_op_decode.sv | 49 ++++
 rtl/alu_issue_ctrl.sv | 163 ++++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage ALU issue controller: ALU control
// codes, opcode/funct encodings, FSM state and the decoded-instruction bundle.
package alu_pkg;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_SLL  = 4'd4;
    localparam logic [3:0] ALU_SRL  = 4'd5;
    localparam logic [3:0] ALU_SLT  = 4'd6;
    localparam logic [3:0] ALU_BEQ  = 4'd7;
    localparam logic [3:0] ALU_BNE  = 4'd8;
    localparam logic [3:0] ALU_BGT  = 4'd9;
    localparam logic [3:0] ALU_BGTE = 4'd10;
    localparam logic [3:0] ALU_BLE  = 4'd11;
    localparam logic [3:0] ALU_BLEQ = 4'd12;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_BGT   = 6'h06;
    localparam logic [5:0] OP_BGTE  = 6'h07;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_BLE   = 6'h14;
    localparam logic [5:0] OP_BLEQ  = 6'h15;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    typedef struct packed {
        logic [3:0] ctrl;
        logic       use_imm;
        logic       sign_ext;
        logic       is_branch;
        logic       is_shift;
        logic       illegal;
    } decode_t;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational opcode/funct decoder: ALU control code, immediate selection
// and extension mode, branch/shift classification and illegal detection.
module alu_op_decode
    import alu_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output decode_t    dec
);

    always_comb begin
        // NOTE: every field gets a default before the case so no path leaves a latch.
        dec = '0;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD:  dec.ctrl = ALU_ADD;
                    FN_SUB:  dec.ctrl = ALU_SUB;
                    FN_AND:  dec.ctrl = ALU_AND;
                    FN_OR:   dec.ctrl = ALU_OR;
                    FN_SLT:  dec.ctrl = ALU_SLT;
                    FN_SLL:  begin dec.ctrl = ALU_SLL; dec.is_shift = 1'b1; end
                    FN_SRL:  begin dec.ctrl = ALU_SRL; dec.is_shift = 1'b1; end
                    default: dec.illegal = 1'b1;
                endcase
            end
            OP_ADDI, OP_LW, OP_SW: begin
                dec.ctrl     = ALU_ADD;
                dec.use_imm  = 1'b1;
                dec.sign_ext = 1'b1;
            end
            OP_SLTI: begin
                dec.ctrl     = ALU_SLT;
                dec.use_imm  = 1'b1;
                dec.sign_ext = 1'b1;
            end
            OP_ANDI: begin dec.ctrl = ALU_AND; dec.use_imm = 1'b1; end
            OP_ORI:  begin dec.ctrl = ALU_OR;  dec.use_imm = 1'b1; end
            OP_BEQ:  begin dec.ctrl = ALU_BEQ;  dec.is_branch = 1'b1; end
            OP_BNE:  begin dec.ctrl = ALU_BNE;  dec.is_branch = 1'b1; end
            OP_BGT:  begin dec.ctrl = ALU_BGT;  dec.is_branch = 1'b1; end
            OP_BGTE: begin dec.ctrl = ALU_BGTE; dec.is_branch = 1'b1; end
            OP_BLE:  begin dec.ctrl = ALU_BLE;  dec.is_branch = 1'b1; end
            OP_BLEQ: begin dec.ctrl = ALU_BLEQ; dec.is_branch = 1'b1; end
            default: dec.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Execute-stage ALU issue controller: accepts a decoded instruction, drives the
// external ALU from registered operands for one cycle, and returns the result.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int DW  = 32,
    parameter int SHW = 5,
    parameter int CW  = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           req_valid,
    output logic           req_ready,
    input  logic [5:0]     req_opcode,
    input  logic [5:0]     req_funct,
    input  logic [SHW-1:0] req_shamt,
    input  logic [DW-1:0]  req_rs,
    input  logic [DW-1:0]  req_rt,
    input  logic [15:0]    req_imm,
    input  logic [DW-1:0]  req_pc,
    output logic [DW-1:0]  alu_in1,
    output logic [DW-1:0]  alu_in2,
    output logic [SHW-1:0] alu_shamt,
    output logic [CW-1:0]  alu_ctrl,
    input  logic [DW-1:0]  alu_out,
    input  logic           alu_zero,
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic [DW-1:0]  rsp_result,
    output logic           rsp_zero,
    output logic           rsp_branch,
    output logic           rsp_taken,
    output logic [DW-1:0]  rsp_target,
    output logic           rsp_err
);

    state_e         state_q, state_d;
    logic [DW-1:0]  alu_in1_q, alu_in1_d;
    logic [DW-1:0]  alu_in2_q, alu_in2_d;
    logic [SHW-1:0] alu_shamt_q, alu_shamt_d;
    logic [CW-1:0]  alu_ctrl_q, alu_ctrl_d;
    logic           branch_q, branch_d;
    logic [DW-1:0]  pc_q, pc_d;
    logic [15:0]    imm_q, imm_d;
    logic [DW-1:0]  rsp_result_q, rsp_result_d;
    logic [DW-1:0]  rsp_target_q, rsp_target_d;
    logic           rsp_zero_q, rsp_zero_d;
    logic           rsp_branch_q, rsp_branch_d;
    logic           rsp_err_q, rsp_err_d;

    decode_t        dec;
    logic [DW-1:0]  ext_imm;
    logic [DW-1:0]  branch_off;

    alu_op_decode u_decode (
        .opcode (req_opcode),
        .funct  (req_funct),
        .dec    (dec)
    );

    assign ext_imm    = dec.sign_ext ? {{(DW-16){req_imm[15]}}, req_imm}
                                     : {{(DW-16){1'b0}}, req_imm};
    assign branch_off = {{(DW-18){imm_q[15]}}, imm_q, 2'b00};

    always_comb begin
        state_d      = state_q;
        alu_in1_d    = alu_in1_q;
        alu_in2_d    = alu_in2_q;
        alu_shamt_d  = alu_shamt_q;
        alu_ctrl_d   = alu_ctrl_q;
        branch_d     = branch_q;
        pc_d         = pc_q;
        imm_d        = imm_q;
        rsp_result_d = rsp_result_q;
        rsp_target_d = rsp_target_q;
        rsp_zero_d   = rsp_zero_q;
        rsp_branch_d = rsp_branch_q;
        rsp_err_d    = rsp_err_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (dec.illegal) begin
                        // Illegal decode skips EXEC and leaves the ALU operands untouched.
                        state_d      = RESP;
                        rsp_err_d    = 1'b1;
                        rsp_result_d = '0;
                        rsp_zero_d   = 1'b0;
                        rsp_branch_d = 1'b0;
                        rsp_target_d = '0;
                    end else begin
                        state_d     = EXEC;
                        alu_ctrl_d  = CW'(dec.ctrl);
                        alu_in1_d   = dec.is_shift ? req_rt : req_rs;
                        alu_in2_d   = dec.use_imm ? ext_imm : req_rt;
                        alu_shamt_d = dec.is_shift ? req_shamt : '0;
                        branch_d    = dec.is_branch;
                        pc_d        = req_pc;
                        imm_d       = req_imm;
                    end
                end
            end
            EXEC: begin
                state_d      = RESP;
                rsp_result_d = alu_out;
                rsp_zero_d   = alu_zero;
                rsp_branch_d = branch_q;
                rsp_target_d = pc_q + DW'(4) + branch_off;
                rsp_err_d    = 1'b0;
            end
            RESP: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            alu_in1_q    <= '0;
            alu_in2_q    <= '0;
            alu_shamt_q  <= '0;
            alu_ctrl_q   <= '0;
            branch_q     <= 1'b0;
            pc_q         <= '0;
            imm_q        <= '0;
            rsp_result_q <= '0;
            rsp_target_q <= '0;
            rsp_zero_q   <= 1'b0;
            rsp_branch_q <= 1'b0;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            alu_in1_q    <= alu_in1_d;
            alu_in2_q    <= alu_in2_d;
            alu_shamt_q  <= alu_shamt_d;
            alu_ctrl_q   <= alu_ctrl_d;
            branch_q     <= branch_d;
            pc_q         <= pc_d;
            imm_q        <= imm_d;
            rsp_result_q <= rsp_result_d;
            rsp_target_q <= rsp_target_d;
            rsp_zero_q   <= rsp_zero_d;
            rsp_branch_q <= rsp_branch_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign rsp_valid  = (state_q == RESP);
    assign alu_in1    = alu_in1_q;
    assign alu_in2    = alu_in2_q;
    assign alu_shamt  = alu_shamt_q;
    assign alu_ctrl   = alu_ctrl_q;
    assign rsp_result = rsp_result_q;
    assign rsp_zero   = rsp_zero_q;
    assign rsp_branch = rsp_branch_q;
    assign rsp_taken  = rsp_branch_q & rsp_zero_q;
    assign rsp_target = rsp_target_q;
    assign rsp_err    = rsp_err_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: acts as the execute-stage ALU and
// checks directed and random instructions against an instruction-level model.
module tb_alu_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready;
    logic [5:0]  req_opcode, req_funct;
    logic [4:0]  req_shamt;
    logic [31:0] req_rs, req_rt, req_pc;
    logic [15:0] req_imm;
    logic [31:0] alu_in1, alu_in2, alu_out;
    logic [4:0]  alu_shamt;
    logic [3:0]  alu_ctrl;
    logic        alu_zero;
    logic        rsp_valid, rsp_ready, rsp_zero, rsp_branch, rsp_taken, rsp_err;
    logic [31:0] rsp_result, rsp_target;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic        err;
        logic        branch;
        logic        zero;
        logic        taken;
        logic [3:0]  ctrl;
        logic [4:0]  shamt;
        logic [31:0] in1;
        logic [31:0] in2;
        logic [31:0] result;
        logic [31:0] target;
    } exp_t;

    exp_t last_e;

    localparam logic [5:0] OP_TBL [0:15] = '{6'h00, 6'h00, 6'h00, 6'h08, 6'h0C, 6'h0D, 6'h0A, 6'h23,
                                             6'h2B, 6'h04, 6'h05, 6'h06, 6'h07, 6'h14, 6'h15, 6'h3F};
    localparam logic [5:0] FN_TBL [0:7]  = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00, 6'h02, 6'h21};

    alu_issue_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_opcode(req_opcode), .req_funct(req_funct), .req_shamt(req_shamt),
        .req_rs(req_rs), .req_rt(req_rt), .req_imm(req_imm), .req_pc(req_pc),
        .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_shamt(alu_shamt), .alu_ctrl(alu_ctrl),
        .alu_out(alu_out), .alu_zero(alu_zero),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_branch(rsp_branch),
        .rsp_taken(rsp_taken), .rsp_target(rsp_target), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    // Execute-stage ALU beside the block; branch codes return 0 when the condition holds.
    always_comb begin
        alu_out = 32'd0;
        case (alu_ctrl)
            4'd0:  alu_out = alu_in1 + alu_in2;
            4'd1:  alu_out = alu_in1 - alu_in2;
            4'd2:  alu_out = alu_in1 & alu_in2;
            4'd3:  alu_out = alu_in1 | alu_in2;
            4'd4:  alu_out = alu_in1 << alu_shamt;
            4'd5:  alu_out = alu_in1 >> alu_shamt;
            4'd6:  alu_out = (alu_in1 <  alu_in2) ? 32'd1 : 32'd0;
            4'd7:  alu_out = (alu_in1 == alu_in2) ? 32'd0 : 32'd1;
            4'd8:  alu_out = (alu_in1 != alu_in2) ? 32'd0 : 32'd1;
            4'd9:  alu_out = (alu_in1 >  alu_in2) ? 32'd0 : 32'd1;
            4'd10: alu_out = (alu_in1 >= alu_in2) ? 32'd0 : 32'd1;
            4'd11: alu_out = (alu_in1 <  alu_in2) ? 32'd0 : 32'd1;
            4'd12: alu_out = (alu_in1 <= alu_in2) ? 32'd0 : 32'd1;
            default: alu_out = 32'd0;
        endcase
        alu_zero = (alu_out == 32'd0);
    end

    // Instruction-level expectation straight from the ISA semantics.
    function automatic exp_t model(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] sh,
                                   input logic [31:0] rs, input logic [31:0] rt,
                                   input logic [15:0] imm, input logic [31:0] pc);
        exp_t e;
        logic [31:0] sx, zx;
        logic cond;
        sx = {{16{imm[15]}}, imm};
        zx = {16'h0000, imm};
        e = '0;
        e.in1 = rs;
        e.in2 = rt;
        cond = 1'b0;
        case (op)
            6'h00: case (fn)
                6'h20: begin e.ctrl = 4'd0; e.result = rs + rt; end
                6'h22: begin e.ctrl = 4'd1; e.result = rs - rt; end
                6'h24: begin e.ctrl = 4'd2; e.result = rs & rt; end
                6'h25: begin e.ctrl = 4'd3; e.result = rs | rt; end
                6'h2A: begin e.ctrl = 4'd6; e.result = (rs < rt) ? 32'd1 : 32'd0; end
                6'h00: begin e.ctrl = 4'd4; e.in1 = rt; e.shamt = sh; e.result = rt << sh; end
                6'h02: begin e.ctrl = 4'd5; e.in1 = rt; e.shamt = sh; e.result = rt >> sh; end
                default: e.err = 1'b1;
            endcase
            6'h08, 6'h23, 6'h2B: begin e.ctrl = 4'd0; e.in2 = sx; e.result = rs + sx; end
            6'h0C: begin e.ctrl = 4'd2; e.in2 = zx; e.result = rs & zx; end
            6'h0D: begin e.ctrl = 4'd3; e.in2 = zx; e.result = rs | zx; end
            6'h0A: begin e.ctrl = 4'd6; e.in2 = sx; e.result = (rs < sx) ? 32'd1 : 32'd0; end
            6'h04: begin e.ctrl = 4'd7;  e.branch = 1'b1; cond = (rs == rt); end
            6'h05: begin e.ctrl = 4'd8;  e.branch = 1'b1; cond = (rs != rt); end
            6'h06: begin e.ctrl = 4'd9;  e.branch = 1'b1; cond = (rs >  rt); end
            6'h07: begin e.ctrl = 4'd10; e.branch = 1'b1; cond = (rs >= rt); end
            6'h14: begin e.ctrl = 4'd11; e.branch = 1'b1; cond = (rs <  rt); end
            6'h15: begin e.ctrl = 4'd12; e.branch = 1'b1; cond = (rs <= rt); end
            default: e.err = 1'b1;
        endcase
        if (e.branch) begin
            e.result = cond ? 32'd0 : 32'd1;
            e.target = pc + 32'd4 + (sx << 2);
        end
        if (e.err) begin
            e = '0;
            e.err = 1'b1;
        end
        e.zero  = !e.err && (e.result == 32'd0);
        e.taken = e.branch && e.zero;
        return e;
    endfunction

    task automatic run_txn(input string name, input logic [5:0] op, input logic [5:0] fn,
                           input logic [4:0] sh, input logic [31:0] rs, input logic [31:0] rt,
                           input logic [15:0] imm, input logic [31:0] pc, input int stall);
        exp_t e;
        int waited;
        e = model(op, fn, sh, rs, rt, imm, pc);
        req_opcode = op; req_funct = fn; req_shamt = sh;
        req_rs = rs; req_rt = rt; req_imm = imm; req_pc = pc;
        req_valid = 1'b1;
        rsp_ready = 1'b0;
        waited = 0;
        while (req_ready !== 1'b1 && waited < 10) begin
            @(posedge clk); #1;
            waited++;
        end
        n_tests++;
        if (req_ready !== 1'b1) begin
            n_fail++; $display("FAIL %s req_ready timeout: got %b want 1", name, req_ready);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_rs = $urandom; req_rt = $urandom; req_imm = 16'($urandom);
        req_pc = $urandom; req_shamt = 5'($urandom);
        if (!e.err) begin
            n_tests++;
            if (rsp_valid !== 1'b0 || alu_ctrl !== e.ctrl || alu_in1 !== e.in1 ||
                alu_in2 !== e.in2 || alu_shamt !== e.shamt) begin
                n_fail++;
                $display("FAIL %s exec: got v=%b ctrl=%0d in1=%h in2=%h sh=%0d want v=0 ctrl=%0d in1=%h in2=%h sh=%0d",
                         name, rsp_valid, alu_ctrl, alu_in1, alu_in2, alu_shamt, e.ctrl, e.in1, e.in2, e.shamt);
            end
            @(posedge clk); #1;
            last_e = e;
        end else begin
            n_tests++;
            if (alu_ctrl !== last_e.ctrl || alu_in1 !== last_e.in1 || alu_in2 !== last_e.in2 ||
                alu_shamt !== last_e.shamt) begin
                n_fail++;
                $display("FAIL %s alu held: got ctrl=%0d in1=%h in2=%h want ctrl=%0d in1=%h in2=%h",
                         name, alu_ctrl, alu_in1, alu_in2, last_e.ctrl, last_e.in1, last_e.in2);
            end
        end
        n_tests++;
        if (rsp_valid !== 1'b1 || rsp_err !== e.err || rsp_result !== e.result || rsp_zero !== e.zero ||
            rsp_branch !== e.branch || rsp_taken !== e.taken || (e.branch && rsp_target !== e.target)) begin
            n_fail++;
            $display("FAIL %s rsp: got v=%b err=%b res=%h z=%b br=%b tk=%b tgt=%h want v=1 err=%b res=%h z=%b br=%b tk=%b tgt=%h",
                     name, rsp_valid, rsp_err, rsp_result, rsp_zero, rsp_branch, rsp_taken, rsp_target,
                     e.err, e.result, e.zero, e.branch, e.taken, e.target);
        end
        repeat (stall) begin
            @(posedge clk); #1;
            n_tests++;
            if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || rsp_result !== e.result || rsp_err !== e.err) begin
                n_fail++;
                $display("FAIL %s stall: got v=%b rdy=%b res=%h err=%b want v=1 rdy=0 res=%h err=%b",
                         name, rsp_valid, req_ready, rsp_result, rsp_err, e.result, e.err);
            end
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        n_tests++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s handshake: got v=%b rdy=%b want v=0 rdy=1", name, rsp_valid, req_ready);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_valid = 1'b1; req_opcode = 6'h00; req_funct = 6'h22; req_shamt = 5'd3;
        req_rs = 32'd9; req_rt = 32'd4; req_imm = 16'h1234; req_pc = 32'h40;
        rsp_ready = 1'b0;
        last_e = '0;
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if (rsp_valid !== 1'b0 || alu_ctrl !== 4'd0 || alu_in1 !== 32'd0 || alu_in2 !== 32'd0 ||
            rsp_result !== 32'd0 || rsp_err !== 1'b0 || rsp_branch !== 1'b0 || rsp_target !== 32'd0) begin
            n_fail++;
            $display("FAIL reset values: got v=%b ctrl=%0d in1=%h in2=%h res=%h err=%b br=%b tgt=%h want all 0",
                     rsp_valid, alu_ctrl, alu_in1, alu_in2, rsp_result, rsp_err, rsp_branch, rsp_target);
        end
        @(negedge clk);
        req_valid = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_tests++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset release: got rdy=%b v=%b want rdy=1 v=0", req_ready, rsp_valid);
        end
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if (rsp_valid !== 1'b0 || alu_ctrl !== 4'd0) begin
            n_fail++; $display("FAIL reset no response: got v=%b ctrl=%0d want v=0 ctrl=0", rsp_valid, alu_ctrl);
        end
    endtask

    task automatic test_add();
        run_txn("add", 6'h00, 6'h20, 5'd0, 32'd5, 32'd7, 16'h0000, 32'h0, 0);
    endtask

    task automatic test_slti_neg();
        run_txn("slti_neg", 6'h0A, 6'h00, 5'd0, 32'd3, 32'd0, 16'hFFFF, 32'h0, 0);
    endtask

    task automatic test_beq_taken();
        run_txn("beq_taken", 6'h04, 6'h00, 5'd0, 32'h10, 32'h10, 16'h0003, 32'h100, 0);
    endtask

    task automatic test_bne_not_taken();
        run_txn("bne_not_taken", 6'h05, 6'h00, 5'd0, 32'h55, 32'h55, 16'h0010, 32'h200, 1);
    endtask

    task automatic test_target_wrap();
        run_txn("target_wrap", 6'h04, 6'h00, 5'd0, 32'h1, 32'h2, 16'h0001, 32'hFFFF_FFF8, 0);
    endtask

    task automatic test_shift();
        run_txn("sll", 6'h00, 6'h00, 5'd4, 32'hDEAD_0000, 32'h0000_00F1, 16'h0000, 32'h0, 0);
        run_txn("srl", 6'h00, 6'h02, 5'd31, 32'h1, 32'h8000_0000, 16'h0000, 32'h0, 0);
    endtask

    task automatic test_illegal();
        run_txn("ori_before_illegal", 6'h0D, 6'h00, 5'd0, 32'hF000_0000, 32'd0, 16'h8001, 32'h0, 0);
        run_txn("illegal_op", 6'h3F, 6'h20, 5'd7, 32'd1, 32'd2, 16'h0004, 32'h80, 2);
        run_txn("illegal_funct", 6'h00, 6'h21, 5'd1, 32'd3, 32'd4, 16'h0000, 32'h0, 0);
    endtask

    task automatic test_back_pressure();
        exp_t e1, e2;
        e1 = model(6'h00, 6'h22, 5'd0, 32'd100, 32'd30, 16'h0, 32'h0);
        e2 = model(6'h00, 6'h25, 5'd0, 32'hF0, 32'h0F, 16'h0, 32'h0);
        req_opcode = 6'h00; req_funct = 6'h22; req_rs = 32'd100; req_rt = 32'd30;
        req_imm = 16'h0; req_pc = 32'h0; req_shamt = 5'd0;
        req_valid = 1'b1; rsp_ready = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        req_funct = 6'h25; req_rs = 32'hF0; req_rt = 32'h0F;
        req_valid = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
            n_tests++;
            if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || rsp_result !== e1.result || alu_ctrl !== e1.ctrl) begin
                n_fail++;
                $display("FAIL bp stall: got v=%b rdy=%b res=%h ctrl=%0d want v=1 rdy=0 res=%h ctrl=%0d",
                         rsp_valid, req_ready, rsp_result, alu_ctrl, e1.result, e1.ctrl);
            end
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        n_tests++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || alu_ctrl !== e1.ctrl) begin
            n_fail++;
            $display("FAIL bp release: got v=%b rdy=%b ctrl=%0d want v=0 rdy=1 ctrl=%0d",
                     rsp_valid, req_ready, alu_ctrl, e1.ctrl);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        n_tests++;
        if (req_ready !== 1'b0 || alu_ctrl !== e2.ctrl || alu_in1 !== e2.in1 || alu_in2 !== e2.in2) begin
            n_fail++;
            $display("FAIL bp second accept: got rdy=%b ctrl=%0d in1=%h in2=%h want rdy=0 ctrl=%0d in1=%h in2=%h",
                     req_ready, alu_ctrl, alu_in1, alu_in2, e2.ctrl, e2.in1, e2.in2);
        end
        @(posedge clk); #1;
        n_tests++;
        if (rsp_valid !== 1'b1 || rsp_result !== e2.result) begin
            n_fail++; $display("FAIL bp second rsp: got v=%b res=%h want v=1 res=%h", rsp_valid, rsp_result, e2.result);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        last_e = e2;
    endtask

    task automatic test_reset_mid_op();
        req_opcode = 6'h00; req_funct = 6'h22; req_rs = 32'd9; req_rt = 32'd2;
        req_imm = 16'h0; req_pc = 32'h0; req_shamt = 5'd0;
        req_valid = 1'b1; rsp_ready = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (rsp_valid !== 1'b0 || rsp_result !== 32'd0 || alu_ctrl !== 4'd0 || alu_in1 !== 32'd0) begin
            n_fail++;
            $display("FAIL reset mid-op: got v=%b res=%h ctrl=%0d in1=%h want all 0",
                     rsp_valid, rsp_result, alu_ctrl, alu_in1);
        end
        @(negedge clk);
        rst_n = 1'b1;
        last_e = '0;
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset mid-op recover: got v=%b rdy=%b want v=0 rdy=1", rsp_valid, req_ready);
        end
    endtask

    task automatic test_random();
        logic [5:0]  op, fn;
        logic [31:0] rs, rt;
        for (int i = 0; i < 150; i++) begin
            op = OP_TBL[$urandom_range(0, 15)];
            fn = FN_TBL[$urandom_range(0, 7)];
            rs = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
            rt = ($urandom_range(0, 3) == 0) ? rs : $urandom;
            run_txn("random", op, fn, 5'($urandom), rs, rt, 16'($urandom), $urandom, $urandom_range(0, 3));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_add();
        test_slti_neg();
        test_beq_taken();
        test_bne_not_taken();
        test_target_wrap();
        test_shift();
        test_illegal();
        test_back_pressure();
        test_reset_mid_op();
        test_illegal();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
